// File: rtl/fm_demodulation.sv
// Zero-crossing FM demodulator: times rising crossings of the carrier and turns each
// accepted period into an offset frequency through a 15-step restoring divider.
module fm_demodulation #(
  parameter int CLK_HZ    = 10000,
  parameter int F_CENTER2 = 200,
  parameter int HYST      = 8,
  parameter int PMIN      = 40,
  parameter int PMAX      = 250
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [7:0] cos_in,
  output logic signed [7:0] demod_out,
  output logic              demod_valid,
  output logic              locked,
  output logic              period_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_DIVIDE  = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  localparam logic [14:0]        DIVIDEND = 15'(2 * CLK_HZ);
  localparam logic signed [7:0]  NEG_HYST = 8'(-HYST);
  localparam logic [7:0]         PMIN_C   = 8'(PMIN);
  localparam logic [7:0]         PMAX_C   = 8'(PMAX);
  localparam logic signed [15:0] CENTER_C = 16'(F_CENTER2);

  function automatic logic signed [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127) begin
      sat8 = 8'sd127;
    end else if (v < -16'sd128) begin
      sat8 = -8'sd128;
    end else begin
      sat8 = v[7:0];
    end
  endfunction

  logic [1:0]         state_r;
  logic signed [7:0]  cos_q_r;
  logic               armed_r;
  logic [7:0]         cnt_r;
  logic [7:0]         div_r;
  logic [7:0]         rem_r;
  logic [14:0]        quo_r;
  logic [3:0]         bit_cnt_r;

  logic               event_s;
  logic               in_range_s;
  logic [8:0]         trial_s;
  logic [8:0]         rem_diff_s;
  logic               fits_s;
  logic [7:0]         rem_next_s;
  logic signed [15:0] diff_s;

  // Crossing event, period range test, one divider step and the centred quotient.
  always_comb begin
    event_s    = armed_r && (cos_q_r >= 8'sd0);
    in_range_s = (cnt_r >= PMIN_C) && (cnt_r <= PMAX_C);
    trial_s    = {rem_r, quo_r[14]};
    rem_diff_s = trial_s - {1'b0, div_r};
    fits_s     = (trial_s >= {1'b0, div_r});
    if (fits_s) begin
      rem_next_s = rem_diff_s[7:0];
    end else begin
      rem_next_s = trial_s[7:0];
    end
    diff_s = $signed({1'b0, quo_r}) - CENTER_C;
  end

  // Input register, crossing detector, period counter, FSM, divider and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cos_q_r     <= 8'sd0;
      armed_r     <= 1'b0;
      cnt_r       <= 8'd0;
      div_r       <= 8'd0;
      rem_r       <= 8'd0;
      quo_r       <= 15'd0;
      bit_cnt_r   <= 4'd0;
      demod_out   <= 8'sd0;
      demod_valid <= 1'b0;
      locked      <= 1'b0;
      period_err  <= 1'b0;
    end else begin
      cos_q_r     <= cos_in;
      demod_valid <= 1'b0;
      period_err  <= 1'b0;

      // One rising crossing per negative excursion below the hysteresis level.
      if (event_s) begin
        armed_r <= 1'b0;
      end else if (cos_q_r < NEG_HYST) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end

      if (event_s) begin
        cnt_r <= 8'd1;
      end else if (cnt_r != 8'd255) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end

      case (state_r)
        S_IDLE: begin
          if (event_s) begin
            state_r <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (event_s) begin
            if (in_range_s) begin
              div_r     <= cnt_r;
              rem_r     <= 8'd0;
              quo_r     <= DIVIDEND;
              bit_cnt_r <= 4'd0;
              state_r   <= S_DIVIDE;
            end else begin
              period_err <= 1'b1;
              locked     <= 1'b0;
            end
          end else if (cnt_r == 8'd255) begin
            period_err <= 1'b1;
            locked     <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
        S_DIVIDE: begin
          rem_r     <= rem_next_s;
          quo_r     <= {quo_r[13:0], fits_s};
          bit_cnt_r <= bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd14) begin
            state_r <= S_OUTPUT;
          end
          if (event_s && !in_range_s) begin
            period_err <= 1'b1;
            locked     <= 1'b0;
          end
        end
        S_OUTPUT: begin
          demod_out   <= sat8(diff_s);
          demod_valid <= 1'b1;
          locked      <= 1'b1;
          state_r     <= S_MEASURE;
          // An event this soon after the last one is always too short.
          if (event_s && !in_range_s) begin
            period_err <= 1'b1;
            locked     <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_demodulation.sv
// Directed bench for fm_demodulation: square-wave carriers of chosen period, checked
// against hand-computed quotients, latencies and error pulses.
module tb_fm_demodulation;

  logic              clk;
  logic              reset;
  logic signed [7:0] cos_in;
  logic signed [7:0] demod_out;
  logic              demod_valid;
  logic              locked;
  logic              period_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cross_cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_err_cyc = 0;
  int last_val = 0;

  fm_demodulation dut (
    .clk         (clk),
    .reset       (reset),
    .cos_in      (cos_in),
    .demod_out   (demod_out),
    .demod_valid (demod_valid),
    .locked      (locked),
    .period_err  (period_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observe what the last posedge produced, then drive the next sample.
  task automatic step(input logic signed [7:0] v);
    @(negedge clk);
    if (demod_valid === 1'b1) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      last_val = demod_out;
    end
    if (period_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    cos_in = v;
    cyc++;
  endtask

  // One carrier period of p clocks; its first (high) sample is the rising crossing.
  task automatic gen_period(input int p);
    cross_cyc = cyc;
    repeat (p / 2) step(8'sd100);
    repeat (p - p / 2) step(-8'sd100);
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    cos_in = 8'sd0;
    #1;
    check("reset_demod_out", demod_out, 0);
    check("reset_valid", demod_valid, 0);
    check("reset_locked", locked, 0);
    check("reset_err", period_err, 0);
    repeat (2) step(8'sd0);
    reset = 1'b0;

    // Hysteresis: -5/0 never arms, so no events, outputs or errors.
    repeat (20) begin
      step(-8'sd5);
      step(8'sd0);
    end
    check("hyst_valid", valid_cnt, 0);
    check("hyst_err", err_cnt, 0);
    check("hyst_locked", locked, 0);

    // -9 arms, +1 is the first crossing; the next crossing lands exactly 100 later.
    step(-8'sd9);
    cross_cyc = cyc;
    repeat (50) step(8'sd1);
    repeat (50) step(-8'sd100);
    check("first_event_no_output", valid_cnt, 0);

    // Nominal 100-clock carrier.
    repeat (4) gen_period(100);
    check("nominal_valid_count", valid_cnt, 4);
    check("nominal_value", last_val, 0);
    check("nominal_err", err_cnt, 0);
    check("nominal_locked", locked, 1);
    check("nominal_interval", last_valid_cyc - prev_valid_cyc, 100);
    // Crossing sample captured at edge c, output on edge c+17, seen at the next negedge.
    check("nominal_latency", last_valid_cyc - cross_cyc, 18);

    // Deviation: each crossing reports the period that preceded it.
    gen_period(80);
    gen_period(125);
    check("p80_value", last_val, 50);
    check("p80_latency", last_valid_cyc - cross_cyc, 18);
    gen_period(147);
    check("p125_value", last_val, -40);
    check("p125_latency", last_valid_cyc - cross_cyc, 18);
    gen_period(61);
    check("p147_value", last_val, -64);
    check("p147_latency", last_valid_cyc - cross_cyc, 18);
    gen_period(40);
    check("p61_value", last_val, 127);
    check("p61_latency", last_valid_cyc - cross_cyc, 18);
    gen_period(100);
    check("p40_value", last_val, 127);
    check("p40_latency", last_valid_cyc - cross_cyc, 18);
    check("deviation_err", err_cnt, 0);
    check("deviation_locked", locked, 1);

    // Out-of-range periods of 30 and 252.
    clear_counts();
    gen_period(30);
    gen_period(252);
    check("short_err_count", err_cnt, 1);
    check("short_err_timing", last_err_cyc - cross_cyc, 2);
    check("short_locked", locked, 0);
    check("short_valid", valid_cnt, 1);
    gen_period(100);
    check("long_err_count", err_cnt, 2);
    check("long_err_timing", last_err_cyc - cross_cyc, 2);
    check("long_locked", locked, 0);
    check("long_valid", valid_cnt, 1);
    gen_period(100);
    check("relock_valid", valid_cnt, 2);
    check("relock_value", last_val, 0);
    check("relock_locked", locked, 1);

    // Timeout: the step to 0 is one last crossing, then the counter saturates.
    clear_counts();
    cross_cyc = cyc;
    repeat (300) step(8'sd0);
    check("timeout_valid", valid_cnt, 1);
    check("timeout_err", err_cnt, 1);
    check("timeout_when", (last_err_cyc - cross_cyc >= 256) && (last_err_cyc - cross_cyc <= 257), 1);
    check("timeout_locked", locked, 0);
    clear_counts();
    repeat (50) step(-8'sd100);
    gen_period(100);
    check("timeout_first_crossing", valid_cnt, 0);
    gen_period(100);
    check("timeout_second_crossing", valid_cnt, 1);
    check("timeout_resume_value", last_val, 0);
    check("timeout_resume_locked", locked, 1);

    // Reset mid-divide, with a non-zero value held beforehand.
    gen_period(80);
    gen_period(125);
    check("pre_reset_value", demod_out, 50);
    clear_counts();
    repeat (6) step(8'sd100);
    #2;
    reset = 1'b1;
    #1;
    check("async_demod_out", demod_out, 0);
    check("async_valid", demod_valid, 0);
    check("async_locked", locked, 0);
    check("async_err", period_err, 0);
    repeat (2) step(8'sd100);
    reset = 1'b0;
    repeat (30) step(8'sd100);
    check("aborted_no_valid", valid_cnt, 0);
    check("aborted_no_err", err_cnt, 0);
    repeat (50) step(-8'sd100);
    gen_period(100);
    check("post_reset_idle", valid_cnt, 0);
    gen_period(100);
    check("post_reset_valid", valid_cnt, 1);
    check("post_reset_value", last_val, 0);
    check("post_reset_locked", locked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
